alarm_time_setter: RTL

Upstream alarm-setting stage for the mm:ss BCD alarm clock. It turns a debounced "up" button and a digit-select switch bank into four BCD alarm digits. Each digit wraps at its own limit: 9 for the one-second and one-minute digits, 5 for the ten-second and ten-minute digits. It compares the alarm digits against the running counter digits and drives a latched alarm-active flag into the song player.

---
 rtl/alarm_time_setter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alarm_time_setter.sv
// Alarm digit setter for the mm:ss BCD alarm clock: button edge detect with
// hold-to-repeat, per-digit wrapping BCD increment, and match/latch of the alarm.
`timescale 1ns/1ps
module alarm_time_setter #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       inc_btn,
  input  logic [3:0] digit_sel,
  input  logic       alarm_reset,
  input  logic       alarm_en,
  input  logic [3:0] t_os,
  input  logic [3:0] t_ts,
  input  logic [3:0] t_om,
  input  logic [3:0] t_tm,
  output logic [3:0] a_os,
  output logic [3:0] a_ts,
  output logic [3:0] a_om,
  output logic [3:0] a_tm,
  output logic       step,
  output logic       alarm_hit,
  output logic       alarm_active
);

  localparam int unsigned MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_t;

  rpt_state_t    state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          btn_q;
  logic          press;
  logic          ev;
  logic          match_c;
  logic          match_q;
  logic          new_hit;

  function automatic logic [3:0] inc_ones(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] inc_tens(input logic [3:0] d);
    return (d >= 4'd5) ? 4'd0 : d + 4'd1;
  endfunction

  assign press = inc_btn & ~btn_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= inc_btn;
    end
  end

  // Repeat FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Repeat FSM: next state; alarm_reset overrides everything
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (alarm_reset) begin
      next_state = IDLE;
      next_cnt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          next_cnt = '0;
          if (press) next_state = HOLD;
        end
        HOLD: begin
          if (!inc_btn) begin
            next_state = IDLE;
            next_cnt   = '0;
          end else if (cnt == DELAY_LAST) begin
            next_state = REPEAT;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!inc_btn) begin
            next_state = IDLE;
            next_cnt   = '0;
          end else if (cnt == RATE_LAST) begin
            next_cnt = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          next_cnt   = '0;
        end
      endcase
    end
  end

  // Repeat FSM: event output
  always_comb begin
    ev = 1'b0;
    if (!alarm_reset) begin
      unique case (state)
        IDLE:    ev = press;
        HOLD:    ev = inc_btn && (cnt == DELAY_LAST);
        REPEAT:  ev = inc_btn && (cnt == RATE_LAST);
        default: ev = 1'b0;
      endcase
    end
  end

  // Lowest set select bit wins; an event with no selected digit is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_os <= '0;
      a_ts <= '0;
      a_om <= '0;
      a_tm <= '0;
      step <= 1'b0;
    end else if (alarm_reset) begin
      a_os <= '0;
      a_ts <= '0;
      a_om <= '0;
      a_tm <= '0;
      step <= 1'b0;
    end else begin
      step <= ev & (|digit_sel);
      if (ev) begin
        if (digit_sel[0])      a_os <= inc_ones(a_os);
        else if (digit_sel[1]) a_ts <= inc_tens(a_ts);
        else if (digit_sel[2]) a_om <= inc_ones(a_om);
        else if (digit_sel[3]) a_tm <= inc_tens(a_tm);
      end
    end
  end

  assign match_c = (a_os == t_os) && (a_ts == t_ts) && (a_om == t_om) && (a_tm == t_tm);
  assign new_hit = alarm_en & match_c & ~match_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q      <= 1'b0;
      alarm_hit    <= 1'b0;
      alarm_active <= 1'b0;
    end else begin
      match_q   <= match_c;
      alarm_hit <= new_hit & ~alarm_reset;
      if (alarm_reset || !alarm_en) begin
        alarm_active <= 1'b0;
      end else if (new_hit) begin
        alarm_active <= 1'b1;
      end
    end
  end

endmodule
